// File: rtl/ceespu_pkg.sv
// Shared widths and the write-port request type for the writeback arbiter slice.
package ceespu_pkg;
  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] sel;
    logic [XLEN-1:0]  data;
  } wb_req_t;
endpackage

// File: rtl/ceespu_scoreboard.sv
// Pending-write bitmap for outstanding long-latency destinations, with three
// combinational query ports for the hazard unit.
module ceespu_scoreboard
  import ceespu_pkg::*;
(
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_setEn,
  input  logic [REG_W-1:0] I_setSel,
  input  logic             I_clrEn,
  input  logic [REG_W-1:0] I_clrSel,
  input  logic [REG_W-1:0] I_selA,
  input  logic [REG_W-1:0] I_selB,
  input  logic [REG_W-1:0] I_selD,
  output logic             O_pendA,
  output logic             O_pendB,
  output logic             O_pendD
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pendNext;

  // Set takes priority so an issue in the drain cycle of the same index survives.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
      assign pendNext[gi] = (I_setEn && I_setSel == REG_W'(gi)) ? 1'b1 :
                            (I_clrEn && I_clrSel == REG_W'(gi)) ? 1'b0 :
                            pend[gi];
    end
  endgenerate

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) pend <= '0;
    else        pend <= pendNext;
  end

  assign O_pendA = pend[I_selA];
  assign O_pendB = pend[I_selB];
  assign O_pendD = pend[I_selD];

endmodule

// File: rtl/ceespu_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a one-entry skid buffer
// holding a long-latency result, with starvation stall and pending-write scoreboard.
module ceespu_wb_arbiter
  import ceespu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_p_we,
  input  logic [REG_W-1:0] I_p_sel,
  input  logic [XLEN-1:0]  I_p_data,
  input  logic             I_l_valid,
  input  logic [REG_W-1:0] I_l_sel,
  input  logic [XLEN-1:0]  I_l_data,
  output logic             O_l_ready,
  input  logic             I_iss_we,
  input  logic [REG_W-1:0] I_iss_sel,
  input  logic [REG_W-1:0] I_selA,
  input  logic [REG_W-1:0] I_selB,
  input  logic [REG_W-1:0] I_selD,
  output logic             O_pendA,
  output logic             O_pendB,
  output logic             O_pendD,
  output logic             O_stall,
  output logic             O_we,
  output logic [REG_W-1:0] O_selD,
  output logic [XLEN-1:0]  O_dataD
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             bufValid;
  logic [REG_W-1:0] bufSel;
  logic [XLEN-1:0]  bufData;
  logic [CNT_W-1:0] starveCnt;

  logic    starve;
  logic    drain;
  logic    lReady;
  logic    accept;
  wb_req_t wbReq;
  logic    pendA;
  logic    pendB;
  logic    pendD;

  assign starve = bufValid && (starveCnt == LIMIT);
  assign drain  = bufValid && (!I_p_we || starve);
  assign lReady = !bufValid || drain;
  assign accept = I_l_valid && lReady;

  always_comb begin
    wbReq = '{we: 1'b0, sel: I_p_sel, data: I_p_data};
    if (I_p_we && !starve) wbReq.we = 1'b1;
    else if (drain)        wbReq = '{we: 1'b1, sel: bufSel, data: bufData};
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      bufValid  <= 1'b0;
      starveCnt <= '0;
    end else begin
      bufValid <= accept || (bufValid && !drain);
      if (!bufValid || drain)  starveCnt <= '0;
      else if (starveCnt != LIMIT) starveCnt <= starveCnt + 1'b1;
    end
  end

  // Payload needs no reset: it is only observed while bufValid is set.
  always_ff @(posedge I_clk) begin
    if (accept) begin
      bufSel  <= I_l_sel;
      bufData <= I_l_data;
    end
  end

  ceespu_scoreboard u_scoreboard (
    .I_clk    (I_clk),
    .I_rst    (I_rst),
    .I_setEn  (I_iss_we),
    .I_setSel (I_iss_sel),
    .I_clrEn  (drain),
    .I_clrSel (bufSel),
    .I_selA   (I_selA),
    .I_selB   (I_selB),
    .I_selD   (I_selD),
    .O_pendA  (pendA),
    .O_pendB  (pendB),
    .O_pendD  (pendD)
  );

  // Control outputs are held inactive for as long as reset is asserted.
  assign O_we      = I_rst && wbReq.we;
  assign O_selD    = wbReq.sel;
  assign O_dataD   = wbReq.data;
  assign O_stall   = I_rst && starve && I_p_we;
  assign O_l_ready = I_rst && lReady;
  assign O_pendA   = I_rst && pendA;
  assign O_pendB   = I_rst && pendB;
  assign O_pendD   = I_rst && pendD;

endmodule

// File: tb/tb_ceespu_wb_arbiter.sv
// Directed self-checking bench for ceespu_wb_arbiter with hand-computed expectations.
module tb_ceespu_wb_arbiter;

  logic        I_clk;
  logic        I_rst;
  logic        I_p_we;
  logic [4:0]  I_p_sel;
  logic [31:0] I_p_data;
  logic        I_l_valid;
  logic [4:0]  I_l_sel;
  logic [31:0] I_l_data;
  logic        O_l_ready;
  logic        I_iss_we;
  logic [4:0]  I_iss_sel;
  logic [4:0]  I_selA;
  logic [4:0]  I_selB;
  logic [4:0]  I_selD;
  logic        O_pendA;
  logic        O_pendB;
  logic        O_pendD;
  logic        O_stall;
  logic        O_we;
  logic [4:0]  O_selD;
  logic [31:0] O_dataD;

  int checks   = 0;
  int failures = 0;

  ceespu_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .I_clk     (I_clk),
    .I_rst     (I_rst),
    .I_p_we    (I_p_we),
    .I_p_sel   (I_p_sel),
    .I_p_data  (I_p_data),
    .I_l_valid (I_l_valid),
    .I_l_sel   (I_l_sel),
    .I_l_data  (I_l_data),
    .O_l_ready (O_l_ready),
    .I_iss_we  (I_iss_we),
    .I_iss_sel (I_iss_sel),
    .I_selA    (I_selA),
    .I_selB    (I_selB),
    .I_selD    (I_selD),
    .O_pendA   (O_pendA),
    .O_pendB   (O_pendB),
    .O_pendD   (O_pendD),
    .O_stall   (O_stall),
    .O_we      (O_we),
    .O_selD    (O_selD),
    .O_dataD   (O_dataD)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // The hazard unit queries the pipeline's own destination on port D.
  assign I_selD = I_p_sel;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h at %0t", tag, obs, $time);
    end
  endtask

  // Pipeline must never write an index that still has a long-latency write pending.
  always @(negedge I_clk) begin
    if (I_rst && I_p_we) checkVal("waw_guard", 32'(O_pendD), 32'd0);
  end

  // Advance to just after the next rising edge, then allow inputs to be driven.
  task automatic nextCycle();
    @(posedge I_clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic we, input logic [4:0] sel,
                            input logic [31:0] data);
    #2;
    checkVal({tag, "_we"}, 32'(O_we), 32'(we));
    if (we) begin
      checkVal({tag, "_sel"}, 32'(O_selD), 32'(sel));
      checkVal({tag, "_data"}, O_dataD, data);
    end
  endtask

  initial begin
    I_rst = 1'b0; I_p_we = 1'b1; I_p_sel = 5'd5; I_p_data = 32'hAA;
    I_l_valid = 1'b1; I_l_sel = 5'd1; I_l_data = 32'h0;
    I_iss_we = 1'b0; I_iss_sel = 5'd0; I_selA = 5'd12; I_selB = 5'd3;

    // Reset state with active inputs: everything gated off.
    repeat (2) nextCycle();
    #2;
    checkVal("rst_we", 32'(O_we), 32'd0);
    checkVal("rst_lready", 32'(O_l_ready), 32'd0);
    checkVal("rst_stall", 32'(O_stall), 32'd0);
    checkVal("rst_pendA", 32'(O_pendA), 32'd0);
    I_l_valid = 1'b0;
    nextCycle();
    I_rst = 1'b1;

    // Pipeline only, three cycles.
    for (int i = 0; i < 3; i++) begin
      checkWrite("pipe", 1'b1, 5'd5, 32'hAA);
      checkVal("pipe_stall", 32'(O_stall), 32'd0);
      nextCycle();
    end
    I_p_we = 1'b0;

    // Idle pipeline: back-to-back long-latency results, each one cycle later.
    I_l_valid = 1'b1; I_l_sel = 5'd7; I_l_data = 32'h1234;
    checkWrite("ll0_idle", 1'b0, 5'd0, 32'h0);
    checkVal("ll0_ready", 32'(O_l_ready), 32'd1);
    nextCycle();
    I_l_sel = 5'd8; I_l_data = 32'h5678;
    checkWrite("ll0_drain", 1'b1, 5'd7, 32'h1234);
    checkVal("ll1_ready", 32'(O_l_ready), 32'd1);
    nextCycle();
    I_l_valid = 1'b0;
    checkWrite("ll1_drain", 1'b1, 5'd8, 32'h5678);
    nextCycle();
    checkWrite("ll_empty", 1'b0, 5'd0, 32'h0);

    // Starvation: buffered sel 9 loses to a busy pipeline for four cycles.
    I_p_we = 1'b1; I_p_sel = 5'd5; I_p_data = 32'h11;
    I_l_valid = 1'b1; I_l_sel = 5'd9; I_l_data = 32'h99;
    checkWrite("stv_acc", 1'b1, 5'd5, 32'h11);
    checkVal("stv_acc_ready", 32'(O_l_ready), 32'd1);
    nextCycle();
    I_l_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      I_p_data = 32'h20 + 32'(i);
      checkWrite("stv_hold", 1'b1, 5'd5, 32'h20 + 32'(i));
      checkVal("stv_hold_stall", 32'(O_stall), 32'd0);
      checkVal("stv_hold_ready", 32'(O_l_ready), 32'd0);
      nextCycle();
    end
    I_p_data = 32'h25;
    checkWrite("stv_force", 1'b1, 5'd9, 32'h99);
    checkVal("stv_force_stall", 32'(O_stall), 32'd1);
    checkVal("stv_force_ready", 32'(O_l_ready), 32'd1);
    nextCycle();
    checkWrite("stv_replay", 1'b1, 5'd5, 32'h25);
    checkVal("stv_replay_stall", 32'(O_stall), 32'd0);
    nextCycle();
    I_p_we = 1'b0;

    // Scoreboard set, query, clear at drain.
    I_p_sel = 5'd12; I_selB = 5'd13;
    I_iss_we = 1'b1; I_iss_sel = 5'd12;
    #2 checkVal("sb_pre", 32'(O_pendA), 32'd0);
    nextCycle();
    I_iss_we = 1'b0;
    #2 checkVal("sb_set", 32'(O_pendA), 32'd1);
    checkVal("sb_setD", 32'(O_pendD), 32'd1);
    checkVal("sb_otherB", 32'(O_pendB), 32'd0);
    nextCycle();
    I_l_valid = 1'b1; I_l_sel = 5'd12; I_l_data = 32'hC0DE;
    nextCycle();
    I_l_valid = 1'b0;
    checkWrite("sb_drain", 1'b1, 5'd12, 32'hC0DE);
    checkVal("sb_drain_pend", 32'(O_pendA), 32'd1);
    nextCycle();
    #2 checkVal("sb_clr", 32'(O_pendA), 32'd0);
    nextCycle();

    // Issue and drain of the same index in one cycle: set wins.
    I_iss_we = 1'b1; I_iss_sel = 5'd12;
    nextCycle();
    I_iss_we = 1'b0;
    I_l_valid = 1'b1; I_l_sel = 5'd12; I_l_data = 32'hBEEF;
    nextCycle();
    I_l_valid = 1'b0;
    I_iss_we = 1'b1; I_iss_sel = 5'd12;
    checkWrite("sb_both", 1'b1, 5'd12, 32'hBEEF);
    nextCycle();
    I_iss_we = 1'b0;
    #2 checkVal("sb_setwins", 32'(O_pendA), 32'd1);
    nextCycle();

    // Reset mid-operation: buffered result plus pend bits 3 and 12.
    I_selB = 5'd3;
    I_iss_we = 1'b1; I_iss_sel = 5'd3;
    I_p_we = 1'b1; I_p_sel = 5'd5; I_p_data = 32'h77;
    I_l_valid = 1'b1; I_l_sel = 5'd20; I_l_data = 32'hDEAD;
    nextCycle();
    I_iss_we = 1'b0; I_l_valid = 1'b0;
    #1;
    checkVal("mid_pendA", 32'(O_pendA), 32'd1);
    checkVal("mid_pendB", 32'(O_pendB), 32'd1);
    checkVal("mid_lready", 32'(O_l_ready), 32'd0);
    I_rst = 1'b0;
    #1;
    checkVal("arst_we", 32'(O_we), 32'd0);
    checkVal("arst_lready", 32'(O_l_ready), 32'd0);
    checkVal("arst_stall", 32'(O_stall), 32'd0);
    checkVal("arst_pendA", 32'(O_pendA), 32'd0);
    checkVal("arst_pendB", 32'(O_pendB), 32'd0);
    I_p_we = 1'b0;
    nextCycle();
    I_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checkWrite("post_idle", 1'b0, 5'd0, 32'h0);
      checkVal("post_pendA", 32'(O_pendA), 32'd0);
      checkVal("post_pendB", 32'(O_pendB), 32'd0);
      checkVal("post_ready", 32'(O_l_ready), 32'd1);
      nextCycle();
    end
    I_l_valid = 1'b1; I_l_sel = 5'd4; I_l_data = 32'h4444;
    nextCycle();
    I_l_valid = 1'b0;
    checkWrite("post_new", 1'b1, 5'd4, 32'h4444);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ceespu_wb_arbiter.md
# ceespu_wb_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and the long-latency unit (load/multiply/divide). It holds one pending long-latency result in a skid buffer, prevents long-latency starvation by briefly stalling the pipeline, and keeps a 32-bit pending-write scoreboard so the hazard unit can stall on RAW/WAW against outstanding long-latency destinations. It sits between the writeback stage and the register file write port (`I_we`/`I_selD`/`I_dataD`).

## Interface
- `STARVE_LIMIT`, 4: consecutive cycles a held result may lose arbitration before `O_stall` is forced; legal range 1..15.
- `CNT_W`, 4: starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- `I_clk` in 1: clock, rising edge.
- `I_rst` in 1: asynchronous, active-low reset.
- `I_p_we` in 1: pipeline writeback valid; no backpressure except via `O_stall`.
- `I_p_sel` in 5: pipeline destination register.
- `I_p_data` in 32: pipeline writeback data.
- `I_l_valid` in 1: long-latency result valid.
- `I_l_sel` in 5: long-latency destination register.
- `I_l_data` in 32: long-latency result data.
- `O_l_ready` out 1: long-latency result accepted when high together with `I_l_valid`.
- `I_iss_we` in 1: a long-latency op with a destination is issuing this cycle.
- `I_iss_sel` in 5: its destination register.
- `I_selA`, `I_selB`, `I_selD` in 5 each: hazard-unit query indices.
- `O_pendA`, `O_pendB`, `O_pendD` out 1 each: scoreboard bit for the corresponding query.
- `O_stall` out 1: pipeline writeback must hold and re-present next cycle.
- `O_we` out 1: register-file write enable.
- `O_selD` out 5: register-file write index.
- `O_dataD` out 32: register-file write data.

## Operation
- State:
  - `buf_valid`, `buf_sel`, `buf_data`: one-entry buffer.
  - `starve_cnt` [CNT_W].
  - `pend` [31:0].
- `starve = buf_valid && starve_cnt == STARVE_LIMIT`.
- `drain = buf_valid && (!I_p_we || starve)`.
- Write port, combinational:
  - If `I_p_we && !starve`: pipeline wins, `O_we=1`, sel/data from `I_p_*`.
  - Else if `drain`: `O_we=1`, sel/data from buffer.
  - Else: `O_we=0`; `O_selD`/`O_dataD` are don't-care but driven from `I_p_*`.
- `O_stall = starve && I_p_we`. When `starve` is high but `I_p_we` is low, no stall is needed.
- `O_l_ready = !buf_valid || drain`. Accept = `I_l_valid && O_l_ready`; it loads the buffer at the clock edge.
- Buffer valid next = accept, or (`buf_valid && !drain`).
- Starvation counter:
  - Increments while `buf_valid && !drain`.
  - Clears on drain and whenever the buffer is empty.
  - Saturates at STARVE_LIMIT.
- Scoreboard:
  - On drain, clear `pend[buf_sel]`.
  - On `I_iss_we`, set `pend[I_iss_sel]`.
  - If both hit the same index in one cycle, set wins.
- Pending queries are combinational: `O_pendX = pend[I_selX]`.
- Register 0 gets no special treatment; all 32 entries are writable.
- Pipeline-vs-buffer same-index write collision cannot occur: the hazard unit stalls WAW via `O_pendD`. The bench asserts this property rather than the RTL resolving it.
- Issue to an already-pending index is illegal, for the same reason; the bit simply stays set.

## Timing
- Reset (`I_rst` low, asynchronous) clears `buf_valid`, `starve_cnt` and `pend`.
- While in reset, outputs are gated: `O_we=0`, `O_l_ready=0`, `O_stall=0`, `O_pendA/B/D=0`.
- Reset mid-operation discards any buffered result. The long-latency unit is reset in the same domain.
- Pipeline write: zero latency; `O_we` is high in the same cycle as `I_p_we`, and the register file captures it at the next edge.
- Long-latency write:
  - Accepted at edge N.
  - Written at edge N+1 at the earliest, since the buffer drains in cycle N+1 if the pipeline is idle.
  - Written no later than edge N+1+STARVE_LIMIT.
- Sustained throughput with an idle pipeline: one long-latency result per cycle, because drain and refill happen in the same cycle.
- The scoreboard bit clears at the drain edge. A reader in the next cycle sees `pend=0` and reads the new value from the register file.

## Structure
- Shared package `ceespu_pkg`: `REG_W=5`, `XLEN=32`, `NREGS=32`, and a `wb_req_t` struct {we, sel, data}.
- One natural sub-module, `ceespu_scoreboard`: the pend bitmap with its set/clear logic and three query ports.
- Arbiter, buffer and starvation counter stay in the top module.

## Test plan
- Pipeline only: `I_p_we=1`, sel 5, data 0xAA for 3 cycles. Expect `O_we=1`, `O_selD=5`, `O_dataD=0xAA`, and `O_stall=0` each cycle.
- Idle pipeline: `I_l_valid` with sel 7, data 0x1234 at edge N. Expect `O_l_ready=1`, then in cycle N+1 `O_we=1`, `O_selD=7`, `O_dataD=0x1234`. Back-to-back results each drain one cycle later.
- Starvation: buffer holds sel 9 while `I_p_we=1` continuously, with STARVE_LIMIT=4. Expect `O_stall=1` in the 5th cycle after accept, with the buffer written that cycle. The pipeline write is re-presented and completes the next cycle.
- Scoreboard: issue sel 12, query `I_selA=12`, and expect `O_pendA=1`. After the sel 12 result drains, the next cycle shows `O_pendA=0`. Issue and drain of sel 12 in the same cycle leaves `O_pendA=1`.
- Reset mid-operation: buffer valid and pend bits 3/12 set, then pulse `I_rst` low asynchronously. Expect all outputs 0 immediately, and no write after release until new requests arrive.
